// File: rtl/ha_311_pkg.sv
// Shared constants and types for the ha_311 half-adder slice.
// Default lane count, default counter width and the per-lane result pair.
package ha_311_pkg;

    localparam int HA_311_WIDTH_DEF = 1;
    localparam int HA_311_CNT_W_DEF = 8;

    // Result of one half-adder lane.
    typedef struct packed {
        logic sum;
        logic carry;
    } ha_311_pair_t;

endpackage : ha_311_pkg

// File: rtl/ha_311_cell.sv
// One-bit combinational half adder: s = a ^ b, c = a & b.
// Leaf cell replicated once per lane by ha_311.
module ha_311_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : ha_311_cell

// File: rtl/ha_311.sv
// WIDTH independent half-adder lanes with combinational and registered sum/carry.
// Optional saturating carry-event counter enabled by macro HA_311_CARRY_CNT_EN.
module ha_311
    import ha_311_pkg::*;
#(
    parameter int WIDTH = HA_311_WIDTH_DEF
`ifdef HA_311_CARRY_CNT_EN
    , parameter int CNT_W = HA_311_CNT_W_DEF
`endif
) (
    input  logic             clk_311,
    input  logic             rst_311,
    input  logic [WIDTH-1:0] a_311,
    input  logic [WIDTH-1:0] b_311,
    output logic [WIDTH-1:0] s_311,
    output logic [WIDTH-1:0] c_311,
    output logic [WIDTH-1:0] s_q_311,
    output logic [WIDTH-1:0] c_q_311
`ifdef HA_311_CARRY_CNT_EN
    , output logic [CNT_W-1:0] carry_cnt_311
`endif
);

    ha_311_pair_t lanes [WIDTH];

    // Lanes never interact, so an X on one input lane stays in that lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_311_cell u_cell (
            .a (a_311[i]),
            .b (b_311[i]),
            .s (lanes[i].sum),
            .c (lanes[i].carry)
        );
        assign s_311[i] = lanes[i].sum;
        assign c_311[i] = lanes[i].carry;
    end

    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) begin
            s_q_311 <= '0;
            c_q_311 <= '0;
        end else begin
            s_q_311 <= s_311;
            c_q_311 <= c_311;
        end
    end

`ifdef HA_311_CARRY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic any_carry;
    assign any_carry = |c_311;

    // Counts edges on which any lane produced a carry; holds at all-ones.
    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) begin
            carry_cnt_311 <= '0;
        end else if (any_carry && (carry_cnt_311 != CNT_MAX)) begin
            carry_cnt_311 <= carry_cnt_311 + 1'b1;
        end
    end
`endif

endmodule : ha_311

// File: tb/tb_ha_311.sv
// Directed bench for ha_311: 1-lane and 4-lane instances, truth table, registers,
// async reset, exhaustive 4-lane sweep and (with HA_311_CARRY_CNT_EN) the counter.
module tb_ha_311;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b1;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic       a1, b1, s1, c1, sq1, cq1;
    logic [3:0] a4, b4, s4, c4, sq4, cq4;
`ifdef HA_311_CARRY_CNT_EN
    logic [1:0] cnt1;
    logic [7:0] cnt4;
`endif

    ha_311 #(
        .WIDTH (1)
`ifdef HA_311_CARRY_CNT_EN
        , .CNT_W (2)
`endif
    ) u_dut1 (
        .clk_311 (clk),
        .rst_311 (rst),
        .a_311   (a1),
        .b_311   (b1),
        .s_311   (s1),
        .c_311   (c1),
        .s_q_311 (sq1),
        .c_q_311 (cq1)
`ifdef HA_311_CARRY_CNT_EN
        , .carry_cnt_311 (cnt1)
`endif
    );

    ha_311 #(
        .WIDTH (4)
    ) u_dut4 (
        .clk_311 (clk),
        .rst_311 (rst),
        .a_311   (a4),
        .b_311   (b4),
        .s_311   (s4),
        .c_311   (c4),
        .s_q_311 (sq4),
        .c_q_311 (cq4)
`ifdef HA_311_CARRY_CNT_EN
        , .carry_cnt_311 (cnt4)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];  // {carry[3:0], sum[3:0]} for the 4-lane instance

    // Rows are {a, b, s, c}, written out by hand.
    logic [3:0] tt [4] = '{4'b0000, 4'b0110, 4'b1010, 4'b1101};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-lane expected value looked up from the hand-written truth table.
    function automatic logic [7:0] lane_model(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] s, c, row;
        for (int l = 0; l < 4; l++) begin
            for (int r = 0; r < 4; r++) begin
                row = tt[r];
                if (row[3] == a[l] && row[2] == b[l]) begin
                    s[l] = row[1];
                    c[l] = row[0];
                end
            end
        end
        return {c, s};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive1(input logic a, input logic b);
        a1 = a;
        b1 = b;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b);
        a4 = a;
        b4 = b;
        exp_q.push_back(lane_model(a, b));
    endtask

    task automatic check4(input string tag);
        logic [7:0] e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=empty_queue exp=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, c4, s4}, {24'd0, e});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #90000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] row;
        drive1(1'b0, 1'b0);
        a4 = 4'b0000;
        b4 = 4'b0000;
        #1;
        check("rst_sq1", 32'(sq1), 32'd0);
        check("rst_cq1", 32'(cq1), 32'd0);
        check("rst_sq4", 32'(sq4), 32'd0);
        check("rst_cq4", 32'(cq4), 32'd0);
`ifdef HA_311_CARRY_CNT_EN
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_cnt4", 32'(cnt4), 32'd0);
`endif
        #1 rst = 1'b0;

        // Truth table, no clock running.
        for (int r = 0; r < 4; r++) begin
            row = tt[r];
            drive1(row[3], row[2]);
            #1;
            check("tt_s", 32'(s1), 32'(row[1]));
            check("tt_c", 32'(c1), 32'(row[0]));
            #49;
        end
        check("noclk_sq1", 32'(sq1), 32'd0);
        check("noclk_cq1", 32'(cq1), 32'd0);

        // 4-lane directed vector, then exhaustive sweep.
        a4 = 4'b1100;
        b4 = 4'b1010;
        #1;
        check("w4_dir_s", 32'(s4), 32'b0110);
        check("w4_dir_c", 32'(c4), 32'b1000);
        for (int i = 0; i < 256; i++) begin
            drive4(4'(i >> 4), 4'(i));
            check4("w4_exh");
        end

        // Registered path.
        clk_en = 1'b1;
        @(negedge clk);
        drive1(1'b1, 1'b1);
        a4 = 4'b1100;
        b4 = 4'b1010;
        tick();
        check("reg_sq_11", 32'(sq1), 32'd0);
        check("reg_cq_11", 32'(cq1), 32'd1);
        check("reg_sq4", 32'(sq4), 32'b0110);
        check("reg_cq4", 32'(cq4), 32'b1000);
        @(negedge clk);
        drive1(1'b0, 1'b1);
        #1;
        check("pre_edge_sq", 32'(sq1), 32'd0);
        check("pre_edge_cq", 32'(cq1), 32'd1);
        tick();
        check("post_edge_sq", 32'(sq1), 32'd1);
        check("post_edge_cq", 32'(cq1), 32'd0);

        // Async reset between edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_sq", 32'(sq1), 32'd0);
        check("arst_cq", 32'(cq1), 32'd0);
        check("arst_sq4", 32'(sq4), 32'd0);
        check("arst_s", 32'(s1), 32'd1);
        check("arst_c", 32'(c1), 32'd0);
        drive1(1'b1, 1'b1);
        tick();
        check("hold_sq", 32'(sq1), 32'd0);
        check("hold_cq", 32'(cq1), 32'd0);
        check("hold_s", 32'(s1), 32'd0);
        check("hold_c", 32'(c1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("first_edge_sq", 32'(sq1), 32'd0);
        check("first_edge_cq", 32'(cq1), 32'd1);

`ifdef HA_311_CARRY_CNT_EN
        // Counter saturation with CNT_W = 2.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("cnt_clr", 32'(cnt1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("cnt_sat", 32'(cnt1), 32'((k > 3) ? 3 : k));
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("cnt_pulse", 32'(cnt1), 32'd0);
        rst = 1'b0;
`endif

        clk_en = 1'b0;
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ha_311
